note_player: RTL and testbench
==============================

// Module: note_player
// PURPOSE
//  Consumes notes from pattern_sequencer and plays each for its length in tempo ticks.
//  Drives pattern_sequencer's i_note_stb to request the next note.
//  Converts pitch to an oscillator phase increment through a pitch ROM.
//  Applies a 4-bit decaying volume envelope selected by the instrument field.
//  Sits between pattern_sequencer and the tone oscillator/mixer.
// PARAMETERS
//  PHASE_W   16  width of pitch ROM word and o_phase_inc
//  LEN_BIAS  1   note duration in ticks = i_note_len + LEN_BIAS (range 1..32 at default)
// PORTS
//  i_clk               in   1        system clock
//  i_rst               in   1        synchronous reset, active-high
//  i_tick              in   1        tempo tick, 1-cycle pulse, spaced >=16 cycles apart
//  o_note_stb          out  1        request next note (to pattern_sequencer i_note_stb)
//  i_note_valid        in   1        note fields valid, 1-cycle pulse
//  i_note_pitch        in   6        pitch index; 0 = rest
//  i_note_len          in   5        length code
//  i_note_instrument   in   4        [3:2] start level, [1:0] decay rate
//  o_pitch_rom_addr    out  6        pitch ROM address
//  i_pitch_rom_data    in   PHASE_W  ROM data, registered ROM, 1-cycle read latency
//  o_phase_inc         out  PHASE_W  oscillator phase increment
//  o_gate              out  1        1 = note sounding
//  o_volume            out  4        envelope level 0..15
// BEHAVIOUR
//  Reset: state IDLE; o_note_stb=0, o_phase_inc=0, o_gate=0, o_volume=0, o_pitch_rom_addr=0.
//   All counters clear. Reset wins over every other input in the same cycle.
//  States: IDLE, WAIT_NOTE, LOOKUP, LOAD, PLAYING.
//  IDLE: on i_tick -> o_note_stb=1 in the next cycle; go to WAIT_NOTE.
//  o_note_stb is registered and high for exactly one cycle per request.
//  WAIT_NOTE:
//   - i_note_valid in cycle N -> latch pitch/len/instrument; go to LOOKUP.
//   - i_tick with no note (sequencer stopped) -> o_gate=0, o_volume=0; stay; no new request.
//   - Previous note outputs hold until a new note loads or such a tick occurs.
//  LOOKUP (cycle N+1): o_pitch_rom_addr = latched pitch.
//   o_pitch_rom_addr holds the last latched pitch in all other states.
//  LOAD (cycle N+2): at the clock edge ending this cycle:
//   - o_phase_inc <= i_pitch_rom_data.
//   - If pitch==0: o_gate <= 0, o_volume <= 0.
//   - Else: o_gate <= 1, o_volume <= {instr[3:2],2'b11} (3/7/11/15).
//   - remaining <= len+LEN_BIAS (6-bit); decay counter cleared; go to PLAYING.
//   New values are visible from cycle N+3.
//  PLAYING, on each i_tick:
//   - remaining decrements.
//   - Envelope steps per instr[1:0]: 0 = hold; 1 = every tick; 2 = every 2nd tick; 3 = every 4th tick.
//   - Each step lowers o_volume by 1, saturating at 0; o_gate stays 1 while pitch!=0.
//   - If remaining was 1: o_note_stb=1 next cycle; go to WAIT_NOTE; outputs held.
//  Ignored inputs and ticks:
//   - i_note_valid outside WAIT_NOTE is ignored.
//   - i_tick in LOOKUP or LOAD is dropped.
//   - i_tick in the same cycle as i_note_valid in WAIT_NOTE is dropped; the note still latches.
//  Tick counting is 6-bit; no wrap, since remaining never exceeds 32.
// TESTING
//  T1 reset, i_tick at cycle 5 -> o_note_stb=1 only at cycle 6; all other outputs 0.
//  T2 note pitch=12 len=2 instr=4'b1100, ROM[12]=16'h1234 at cycle N:
//     -> addr=12 at N+1; from N+3 phase_inc=16'h1234, gate=1, vol=15;
//     -> o_note_stb pulse one cycle after the 3rd tick.
//  T3 instr=4'b1101, len=31: vol 15,14,...,0 on successive ticks, stays 0;
//     gate=1 until the 32nd tick; then o_note_stb.
//  T3b instr=4'b0110: vol 7, drops by 1 every 2nd tick.
//  T4 rest: pitch=0 len=0 -> gate=0, vol=0 from N+3; o_note_stb one cycle after the next tick.
//  T5 no i_note_valid after a request, then i_tick -> gate=0, vol=0, no o_note_stb;
//     a later i_note_valid still loads normally.
//  T6 i_note_valid while PLAYING -> ignored, duration unchanged.
//     i_rst mid-note -> all outputs 0 next cycle; the first tick after release re-requests.

Source files
------------

// File: rtl/note_player.sv
// ---------------------------------------------------------------------------
// note_player
//
// Plays notes handed over by pattern_sequencer. Each note is held for its
// length in tempo ticks. Its pitch is turned into an oscillator phase
// increment through an external registered pitch ROM. A small decaying 4-bit
// envelope, chosen by the instrument field, shapes the volume. When a note
// runs out, a one-cycle strobe asks the sequencer for the next note.
//
// Parameters
//   PHASE_W   width of the pitch ROM word and of o_phase_inc
//   LEN_BIAS  added to the length code to give the duration in ticks
//
// Ports
//   i_clk              system clock
//   i_rst              synchronous reset, active-high
//   i_tick             tempo tick, single-cycle pulse
//   o_note_stb         single-cycle request for the next note
//   i_note_valid       note fields valid, single-cycle pulse
//   i_note_pitch       pitch index, 0 = rest
//   i_note_len         length code
//   i_note_instrument  [3:2] start level, [1:0] decay rate
//   o_pitch_rom_addr   pitch ROM address (last latched pitch)
//   i_pitch_rom_data   pitch ROM word, one cycle after the address
//   o_phase_inc        oscillator phase increment
//   o_gate             1 while a pitched note is sounding
//   o_volume           envelope level 0..15
// ---------------------------------------------------------------------------
module note_player #(
   parameter int PHASE_W  = 16,
   parameter int LEN_BIAS = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_tick,
   output logic               o_note_stb,
   input  logic               i_note_valid,
   input  logic [5:0]         i_note_pitch,
   input  logic [4:0]         i_note_len,
   input  logic [3:0]         i_note_instrument,
   output logic [5:0]         o_pitch_rom_addr,
   input  logic [PHASE_W-1:0] i_pitch_rom_data,
   output logic [PHASE_W-1:0] o_phase_inc,
   output logic               o_gate,
   output logic [3:0]         o_volume
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_NOTE,
      LOOKUP,
      LOAD,
      PLAYING
   } state_t;

   state_t               state;
   state_t               nxt_state;

   logic                 note_stb;
   logic                 nxt_note_stb;
   logic [5:0]           pitch_q;
   logic [5:0]           nxt_pitch_q;
   logic [4:0]           len_q;
   logic [4:0]           nxt_len_q;
   logic [3:0]           instr_q;
   logic [3:0]           nxt_instr_q;
   logic [PHASE_W-1:0]   phase_inc;
   logic [PHASE_W-1:0]   nxt_phase_inc;
   logic                 gate;
   logic                 nxt_gate;
   logic [3:0]           volume;
   logic [3:0]           nxt_volume;
   logic [5:0]           remaining;
   logic [5:0]           nxt_remaining;
   logic [1:0]           decay_cnt;
   logic [1:0]           nxt_decay_cnt;
   logic                 env_step;

   // The envelope steps on a subset of ticks chosen by the decay rate.
   // decay_cnt holds the number of ticks already seen in this note, so
   // "every 2nd tick" fires when the count is odd and "every 4th tick"
   // fires when it is 3. The counter simply wraps, which keeps the pattern
   // repeating for long notes.
   always_comb begin
      env_step = 1'b0;
      case (instr_q[1:0])
         2'd0:    env_step = 1'b0;
         2'd1:    env_step = 1'b1;
         2'd2:    env_step = decay_cnt[0];
         default: env_step = (decay_cnt == 2'd3);
      endcase
   end

   // Next-state and next-output logic. Every registered value defaults to
   // holding, and the strobe defaults low so it can only ever be a
   // single-cycle pulse. The pitch register doubles as the ROM address, so
   // the address changes exactly when a note is latched and holds otherwise.
   always_comb begin
      nxt_state     = state;
      nxt_note_stb  = 1'b0;
      nxt_pitch_q   = pitch_q;
      nxt_len_q     = len_q;
      nxt_instr_q   = instr_q;
      nxt_phase_inc = phase_inc;
      nxt_gate      = gate;
      nxt_volume    = volume;
      nxt_remaining = remaining;
      nxt_decay_cnt = decay_cnt;

      case (state)
         IDLE: begin
            if (i_tick) begin
               nxt_note_stb = 1'b1;
               nxt_state    = WAIT_NOTE;
            end
         end

         // A note wins over a tick in the same cycle; that tick is dropped.
         // A lone tick means the sequencer has nothing to give, so the
         // output goes silent and the block keeps waiting without asking
         // again.
         WAIT_NOTE: begin
            if (i_note_valid) begin
               nxt_pitch_q = i_note_pitch;
               nxt_len_q   = i_note_len;
               nxt_instr_q = i_note_instrument;
               nxt_state   = LOOKUP;
            end else if (i_tick) begin
               nxt_gate   = 1'b0;
               nxt_volume = 4'd0;
            end
         end

         // The ROM is registered, so this cycle only waits for the data.
         LOOKUP: begin
            nxt_state = LOAD;
         end

         // ROM data is valid now. A rest keeps gate and volume at zero;
         // a pitched note starts at one of the levels 3/7/11/15.
         LOAD: begin
            nxt_phase_inc = i_pitch_rom_data;
            if (pitch_q == 6'd0) begin
               nxt_gate   = 1'b0;
               nxt_volume = 4'd0;
            end else begin
               nxt_gate   = 1'b1;
               nxt_volume = {instr_q[3:2], 2'b11};
            end
            nxt_remaining = {1'b0, len_q} + 6'(LEN_BIAS);
            nxt_decay_cnt = 2'd0;
            nxt_state     = PLAYING;
         end

         // Each tick counts the note down and steps the envelope. When the
         // last tick of the note arrives, the next note is requested and
         // the outputs are left as they are until it loads.
         PLAYING: begin
            if (i_tick) begin
               nxt_remaining = remaining - 6'd1;
               nxt_decay_cnt = decay_cnt + 2'd1;
               if (env_step && (volume != 4'd0)) begin
                  nxt_volume = volume - 4'd1;
               end
               if (remaining == 6'd1) begin
                  nxt_note_stb = 1'b1;
                  nxt_state    = WAIT_NOTE;
               end
            end
         end

         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // State and output registers. Reset is synchronous and overrides
   // everything else that happens in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         note_stb  <= 1'b0;
         pitch_q   <= 6'd0;
         len_q     <= 5'd0;
         instr_q   <= 4'd0;
         phase_inc <= '0;
         gate      <= 1'b0;
         volume    <= 4'd0;
         remaining <= 6'd0;
         decay_cnt <= 2'd0;
      end else begin
         state     <= nxt_state;
         note_stb  <= nxt_note_stb;
         pitch_q   <= nxt_pitch_q;
         len_q     <= nxt_len_q;
         instr_q   <= nxt_instr_q;
         phase_inc <= nxt_phase_inc;
         gate      <= nxt_gate;
         volume    <= nxt_volume;
         remaining <= nxt_remaining;
         decay_cnt <= nxt_decay_cnt;
      end
   end

   assign o_note_stb       = note_stb;
   assign o_pitch_rom_addr = pitch_q;
   assign o_phase_inc      = phase_inc;
   assign o_gate           = gate;
   assign o_volume         = volume;

endmodule

// File: tb/tb_note_player.sv
// ---------------------------------------------------------------------------
// tb_note_player
//
// Drives note_player with directed notes and ticks. It models the registered
// pitch ROM with a small table. Expected strobe cycles and output snapshots
// are queued when stimulus is issued. A monitor running on the falling edge
// pops and compares them as the DUT reaches those cycles, and flags any
// strobe nobody asked for.
// ---------------------------------------------------------------------------
module tb_note_player;

   typedef struct {
      int          cyc;
      logic [15:0] phase;
      logic        gate;
      logic [3:0]  vol;
      logic [5:0]  addr;
      string       name;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        note_stb;
   logic        note_valid;
   logic [5:0]  note_pitch;
   logic [4:0]  note_len;
   logic [3:0]  note_instr;
   logic [5:0]  rom_addr;
   logic [15:0] rom_data;
   logic [15:0] phase_inc;
   logic        gate;
   logic [3:0]  volume;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          stb_q[$];
   snap_t       snap_q[$];

   note_player #(.PHASE_W(16), .LEN_BIAS(1)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_tick            (tick),
      .o_note_stb        (note_stb),
      .i_note_valid      (note_valid),
      .i_note_pitch      (note_pitch),
      .i_note_len        (note_len),
      .i_note_instrument (note_instr),
      .o_pitch_rom_addr  (rom_addr),
      .i_pitch_rom_data  (rom_data),
      .o_phase_inc       (phase_inc),
      .o_gate            (gate),
      .o_volume          (volume)
   );

   always #5 clk = ~clk;

   // Cycle counter: at a falling edge, cyc names the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   // Registered pitch ROM with hand-picked words for the pitches used.
   always @(posedge clk) begin
      case (rom_addr)
         6'd0:    rom_data <= 16'hA015;
         6'd5:    rom_data <= 16'hA155;
         6'd7:    rom_data <= 16'hA1D5;
         6'd12:   rom_data <= 16'h1234;
         6'd20:   rom_data <= 16'hA515;
         default: rom_data <= 16'hDEAD;
      endcase
   end

   // Monitor: compare every strobe and every due snapshot.
   task automatic checkOutput();
      snap_t s;
      while (stb_q.size() > 0 && stb_q[0] < cyc) begin
         checks++;
         errors++;
         $display("[TB] FAIL note_stb_missing: actual no pulse, required pulse at cycle %0d", stb_q[0]);
         void'(stb_q.pop_front());
      end
      if (note_stb === 1'b1) begin
         checks++;
         if (stb_q.size() > 0 && stb_q[0] == cyc) begin
            void'(stb_q.pop_front());
         end else begin
            errors++;
            $display("[TB] FAIL note_stb_unexpected: actual pulse at cycle %0d, required none", cyc);
         end
      end
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
         s = snap_q.pop_front();
         checks++;
         if (s.cyc < cyc) begin
            errors++;
            $display("[TB] FAIL %s: snapshot for cycle %0d was never sampled", s.name, s.cyc);
         end else if (phase_inc !== s.phase || gate !== s.gate ||
                      volume !== s.vol || rom_addr !== s.addr) begin
            errors++;
            $display("[TB] FAIL %s @%0d: actual phase=%h gate=%b vol=%0d addr=%0d, required phase=%h gate=%b vol=%0d addr=%0d",
                     s.name, cyc, phase_inc, gate, volume, rom_addr,
                     s.phase, s.gate, s.vol, s.addr);
         end
      end
   endtask

   always @(negedge clk) checkOutput();

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pushSnap(input int c, input logic [15:0] ph, input logic g,
                           input logic [3:0] v, input logic [5:0] a, input string nm);
      snap_t s;
      s.cyc = c; s.phase = ph; s.gate = g; s.vol = v; s.addr = a; s.name = nm;
      snap_q.push_back(s);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one cycle of inputs, starting at a falling edge.
   task automatic applyStimulus(input logic t, input logic v, input logic r,
                                input logic [5:0] p, input logic [4:0] l,
                                input logic [3:0] ins);
      tick = t; note_valid = v; rst = r;
      note_pitch = p; note_len = l; note_instr = ins;
      @(negedge clk);
      tick = 1'b0; note_valid = 1'b0; rst = 1'b0;
   endtask

   // One tick followed by enough idle cycles to respect tick spacing.
   task automatic doTick(input bit exp_stb, input bit chk, input logic [15:0] ph,
                         input logic g, input logic [3:0] v, input logic [5:0] a,
                         input string nm);
      int t;
      t = cyc;
      if (exp_stb) stb_q.push_back(t + 1);
      if (chk) pushSnap(t + 1, ph, g, v, a, nm);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 4'd0);
      idle(15);
   endtask

   // Present a note and check the loaded outputs three cycles later.
   // Optionally a tick rides with the note or lands in LOOKUP; both are
   // dropped by the DUT.
   task automatic doNote(input logic [5:0] p, input logic [4:0] l, input logic [3:0] ins,
                         input bit tick_with, input bit tick_lookup,
                         input logic [15:0] ph, input logic g, input logic [3:0] v,
                         input string nm);
      int n;
      n = cyc;
      pushSnap(n + 3, ph, g, v, p, nm);
      applyStimulus(tick_with, 1'b1, 1'b0, p, l, ins);
      if (tick_lookup) applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 4'd0);
      else idle(1);
      idle(2);
   endtask

   initial begin
      rst = 1'b0; tick = 1'b0; note_valid = 1'b0;
      note_pitch = 6'd0; note_len = 5'd0; note_instr = 4'd0;
      @(negedge clk);

      // Reset, with a tick during reset that must not cause a request.
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 4'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 5'd0, 4'd0);
      pushSnap(cyc + 1, 16'h0000, 1'b0, 4'd0, 6'd0, "reset_state");
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 4'd0);
      idle(3);

      // T1: first tick requests a note, other outputs stay 0.
      doTick(1'b1, 1'b1, 16'h0000, 1'b0, 4'd0, 6'd0, "t1_request");

      // T2: pitch 12, len 2, start level 15, no decay -> 3 ticks.
      pushSnap(cyc + 1, 16'h0000, 1'b0, 4'd0, 6'd12, "t2_lookup_addr");
      doNote(6'd12, 5'd2, 4'b1100, 1'b0, 1'b0, 16'h1234, 1'b1, 4'd15, "t2_load");
      doTick(1'b0, 1'b1, 16'h1234, 1'b1, 4'd15, 6'd12, "t2_tick1");
      doTick(1'b0, 1'b1, 16'h1234, 1'b1, 4'd15, 6'd12, "t2_tick2");
      doTick(1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 6'd0, "");

      // T3: len 31 -> 32 ticks; decay every tick from 15, saturating at 0.
      pushSnap(cyc + 1, 16'h1234, 1'b1, 4'd15, 6'd5, "t3_held_outputs");
      doNote(6'd5, 5'd31, 4'b1101, 1'b0, 1'b0, 16'hA155, 1'b1, 4'd15, "t3_load");
      for (int k = 1; k <= 32; k++) begin
         doTick(k == 32, 1'b1, 16'hA155, 1'b1,
                (k >= 15) ? 4'd0 : 4'(15 - k), 6'd5, "t3_decay");
      end

      // T3b: start 7, decay every 2nd tick; len 5 -> 6 ticks.
      doNote(6'd7, 5'd5, 4'b0110, 1'b0, 1'b0, 16'hA1D5, 1'b1, 4'd7, "t3b_load");
      for (int k = 1; k <= 6; k++) begin
         doTick(k == 6, k < 6, 16'hA1D5, 1'b1, 4'(7 - k / 2), 6'd7, "t3b_decay");
      end

      // T5: no note arrives, a tick silences the output without a request.
      doTick(1'b0, 1'b1, 16'hA1D5, 1'b0, 4'd0, 6'd7, "t5_silence");
      doNote(6'd20, 5'd1, 4'b1000, 1'b0, 1'b0, 16'hA515, 1'b1, 4'd11, "t5_late_load");

      // T6a: a note offered while playing is ignored; duration stays 2 ticks.
      doTick(1'b0, 1'b1, 16'hA515, 1'b1, 4'd11, 6'd20, "t6_tick1");
      pushSnap(cyc + 1, 16'hA515, 1'b1, 4'd11, 6'd20, "t6_ignored_note");
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd3, 5'd9, 4'b0101);
      idle(14);
      doTick(1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 6'd0, "");

      // T4: rest with len 0; a tick during LOOKUP is dropped, the next ends it.
      doNote(6'd0, 5'd0, 4'b1111, 1'b0, 1'b1, 16'hA015, 1'b0, 4'd0, "t4_rest_load");
      idle(13);
      doTick(1'b1, 1'b1, 16'hA015, 1'b0, 4'd0, 6'd0, "t4_rest_end");

      // T6b: a tick together with the note is dropped, the note still loads;
      // reset mid-note clears everything and the next tick re-requests.
      doNote(6'd12, 5'd3, 4'b1100, 1'b1, 1'b0, 16'h1234, 1'b1, 4'd15, "t6_tick_with_note");
      idle(12);
      doTick(1'b0, 1'b1, 16'h1234, 1'b1, 4'd15, 6'd12, "t6_playing");
      pushSnap(cyc + 1, 16'h0000, 1'b0, 4'd0, 6'd0, "t6_mid_note_reset");
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 4'd0);
      idle(3);
      doTick(1'b1, 1'b1, 16'h0000, 1'b0, 4'd0, 6'd0, "t6_rerequest");

      idle(20);
      while (stb_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL note_stb_pending: actual no pulse, required pulse at cycle %0d", stb_q[0]);
         void'(stb_q.pop_front());
      end
      while (snap_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: snapshot for cycle %0d never reached", snap_q[0].name, snap_q[0].cyc);
         void'(snap_q.pop_front());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
